reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor to the core's 2-read/1-write register file.
- Adds configurable XLEN and register count, and a per-register busy scoreboard (set at issue, cleared at writeback) for multicycle units.
- Adds a sequenced bulk-clear sweep for pipeline flush and restart.
- Sits between the decode stage (read and issue) and the writeback stage (write).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers. Power of two, at least 4. Register 0 is hardwired zero.
- AW, $clog2(NREG), address width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- rd_addr1  input  AW  read port 1 address
- rd_addr2  input  AW  read port 2 address
- rd_data1  output  XLEN  read port 1 data (combinational)
- rd_data2  output  XLEN  read port 2 data (combinational)
- rd_busy1  output  1  busy bit of rd_addr1 (combinational)
- rd_busy2  output  1  busy bit of rd_addr2 (combinational)
- wr_en  input  1  writeback write enable
- wr_addr  input  AW  writeback address
- wr_data  input  XLEN  writeback data
- set_en  input  1  issue: mark set_addr busy
- set_addr  input  AW  register to mark busy
- clr_req  input  1  request a bulk clear sweep (single-cycle pulse or level)
- sweeping  output  1  sweep in progress
- ready  output  1  accepts wr_en/set_en; equals the inverse of sweeping

Behaviour:
- Reset is asynchronous and active-high: all NREG registers = 0, all busy bits = 0, FSM = IDLE, sweep index = 1, sweeping = 0, ready = 1.
- Reset asserted mid-sweep aborts the sweep immediately; FSM returns to IDLE.
- Read ports are combinational. Address 0 always returns data 0 and busy 0.
- Without bypass, a same-cycle write is not visible on reads until the next cycle.
- Write: on posedge, if wr_en and ready and wr_addr != 0, store wr_data and clear busy[wr_addr].
- Issue: on posedge, if set_en and ready and set_addr != 0, set busy[set_addr] = 1.
- wr_en and set_en on the same nonzero address in the same cycle: data is written and busy ends at 1 (new producer wins).
- wr_en and set_en on different addresses in the same cycle are independent.
- FSM states:
  - IDLE: sweeping = 0. If clr_req, go to SWEEP next cycle, clear all busy bits at that edge, and load idx = 1. Writes or sets in that same cycle are still honoured for data; all busy bits end at 0.
  - SWEEP: sweeping = 1, ready = 0. Each cycle write 0 to register idx and increment idx. wr_en, set_en and clr_req are ignored (dropped, not queued). When idx = NREG-1 has been cleared, go to IDLE.
- Sweep length is exactly NREG-1 cycles in SWEEP. ready rises on the cycle after the last clear.
- Reads during a sweep return current array contents: already-swept registers read 0, unswept registers read old values.
- idx is AW bits wide and never wraps through 0 (the sweep terminates at NREG-1).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding. When wr_en && ready && wr_addr != 0 && rd_addrN == wr_addr, rd_dataN = wr_data in the same cycle. rd_busyN is not forwarded; it still shows the stored bit.
- Not defined: reads return stored contents only; a write becomes visible the cycle after its edge.

Test Plan:
- Reset then read all addresses -> rd_data = 0 and rd_busy = 0 everywhere; ready = 1, sweeping = 0.
- Write x5 = 0xDEADBEEF, then read rd_addr1 = 5 next cycle -> 0xDEADBEEF. Write x0 = 0x1234 -> read x0 = 0.
- set_en x7, then read -> rd_busy = 1. wr_en x7 = 0x55 -> next cycle busy = 0 and data = 0x55. Same-cycle set_en and wr_en on x9 = 0xAA -> data 0xAA, busy 1.
- Fill x1..x31 with nonzero values, pulse clr_req -> sweeping high for exactly 31 cycles. A wr_en x3 = 0x77 mid-sweep is dropped. Afterwards all registers and busy bits = 0 and ready = 1.
- Assert rst at sweep cycle 10 -> immediate return to IDLE; all registers 0, sweeping = 0.
- With REGFILE_BYPASS_EN: wr_en x4 = 0xCAFE and rd_addr2 = 4 in the same cycle -> rd_data2 = 0xCAFE that cycle. Without the macro -> old value that cycle, 0xCAFE the next.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised 2-read/1-write register file with per-register busy scoreboard
// and a sequenced bulk-clear sweep. Define REGFILE_BYPASS_EN for write-first read forwarding.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  output logic            rd_busy1,
  output logic            rd_busy2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_req,
  output logic            sweeping,
  output logic            ready
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q;
  logic [XLEN-1:0]     regs [NREG];
  logic [NREG-1:0]     busy_q;
  logic                wr_fire;
  logic                set_fire;
  logic                clr_start;

  // Handshake: wr_en/set_en are accepted only on an edge where ready is high;
  // while sweeping they are dropped, never queued. clr_req is sampled in IDLE only.
  assign wr_fire   = wr_en  && ready && (wr_addr  != '0);
  assign set_fire  = set_en && ready && (set_addr != '0);
  assign clr_start = (state_q == IDLE) && clr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sweeping = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) state_d = SWEEP;
      end
      SWEEP: begin
        sweeping = 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = ~sweeping;

  // Register array and sweep index; register 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= AW'(1);
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wr_fire) regs[wr_addr] <= wr_data;
      if (sweeping) begin
        regs[idx_q] <= '0;
        // Reload to 1 after the last register so the index never passes through 0.
        idx_q <= (idx_q == LAST_IDX) ? AW'(1) : idx_q + AW'(1);
      end
    end
  end

  // Same-address set and write: the set is applied last so the new producer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else if (clr_start) begin
      busy_q <= '0;
    end else begin
      if (wr_fire)  busy_q[wr_addr]  <= 1'b0;
      if (set_fire) busy_q[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
    rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
    if (BYPASS && wr_fire && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if (BYPASS && wr_fire && (wr_addr == rd_addr2)) rd_data2 = wr_data;
    rd_busy1 = (rd_addr1 == '0) ? 1'b0 : busy_q[rd_addr1];
    rd_busy2 = (rd_addr2 == '0) ? 1'b0 : busy_q[rd_addr2];
  end

endmodule
